// File: rtl/l2_bank_adapter.sv
// l2_bank_adapter: per-bank endpoint behind one L2 crossbar slave port.
// Turns TCDM-style requests into accesses on a single-port SRAM that has no
// byte enables. Partial-byte writes become a two-cycle read-modify-write.
// Responses come back exactly one cycle after the grant.
// Optional build macro: L2_BANK_ADAPTER_ADDR_CHECK_EN. When it is defined, any
// request with address bits set above the word-index field is answered with an
// error and does not touch the SRAM.
module l2_bank_adapter #(
    parameter int CFI_DATA_WIDTH  = 40,
    parameter int BE_WIDTH        = 5,
    parameter int ADDR_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int ADDR_LSB        = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [ADDR_WIDTH-1:0]      add_i,
    input  logic                       wen_i,
    input  logic [BE_WIDTH-1:0]        be_i,
    input  logic [CFI_DATA_WIDTH-1:0]  wdata_i,
    output logic                       gnt_o,
    output logic                       r_valid_o,
    output logic [CFI_DATA_WIDTH-1:0]  r_rdata_o,
    output logic                       r_opc_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [BANK_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [CFI_DATA_WIDTH-1:0]  mem_wdata_o,
    input  logic [CFI_DATA_WIDTH-1:0]  mem_rdata_i
);

    localparam int LANE_WIDTH = CFI_DATA_WIDTH / BE_WIDTH;
    localparam int UPPER_LSB  = ADDR_LSB + BANK_ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        RMW_MERGE
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic [BANK_ADDR_WIDTH-1:0] r_addr;
    logic [BE_WIDTH-1:0]        r_be;
    logic [CFI_DATA_WIDTH-1:0]  r_wdata;
    logic                       r_valid;
    logic                       r_was_read;
    logic                       r_opc;

    logic [BANK_ADDR_WIDTH-1:0] w_idx;
    logic                       w_be_full;
    logic                       w_be_none;
    logic                       w_oob;
    logic                       w_unused_addr;
    logic [CFI_DATA_WIDTH-1:0]  w_merged;

    logic                       w_gnt;
    logic                       w_mem_req;
    logic                       w_mem_we;
    logic [BANK_ADDR_WIDTH-1:0] w_mem_addr;
    logic [CFI_DATA_WIDTH-1:0]  w_mem_wdata;
    logic                       w_latch;
    logic                       w_resp_read;
    logic                       w_resp_opc;

    assign w_idx     = add_i[ADDR_LSB +: BANK_ADDR_WIDTH];
    assign w_be_full = &be_i;
    assign w_be_none = ~|be_i;

    // Byte-offset bits never matter, and upper bits only matter for the check.
    assign w_unused_addr = ^{add_i[ADDR_WIDTH-1:UPPER_LSB], add_i[ADDR_LSB-1:0]};

`ifdef L2_BANK_ADAPTER_ADDR_CHECK_EN
    assign w_oob = |add_i[ADDR_WIDTH-1:UPPER_LSB];
`else
    assign w_oob = 1'b0;
`endif

    // Build the RMW word: enabled lanes from the latched write data, the rest from the SRAM.
    always_comb begin
        w_merged = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            w_merged[i*LANE_WIDTH +: LANE_WIDTH] = r_be[i] ? r_wdata[i*LANE_WIDTH +: LANE_WIDTH]
                                                           : mem_rdata_i[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // Next-state, grant and SRAM strobe decode; partial writes hold off the grant for one cycle.
    always_comb begin
        w_next_state = r_state;
        w_gnt        = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_latch      = 1'b0;
        w_resp_read  = 1'b0;
        w_resp_opc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    if (w_oob) begin
                        w_gnt      = 1'b1;
                        w_resp_opc = 1'b1;
                    end else if (wen_i) begin
                        w_gnt       = 1'b1;
                        w_mem_req   = 1'b1;
                        w_mem_addr  = w_idx;
                        w_resp_read = 1'b1;
                    end else if (w_be_full) begin
                        w_gnt       = 1'b1;
                        w_mem_req   = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_addr  = w_idx;
                        w_mem_wdata = wdata_i;
                    end else if (w_be_none) begin
                        w_gnt = 1'b1;
                    end else begin
                        w_mem_req    = 1'b1;
                        w_mem_addr   = w_idx;
                        w_latch      = 1'b1;
                        w_next_state = RMW_MERGE;
                    end
                end
            end
            RMW_MERGE: begin
                w_next_state = IDLE;
                if (req_i) begin
                    w_gnt       = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = w_merged;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced to their idle values while reset is held.
    assign gnt_o       = w_gnt & ~rst_i;
    assign mem_req_o   = w_mem_req & ~rst_i;
    assign mem_we_o    = w_mem_we & ~rst_i;
    assign mem_addr_o  = rst_i ? '0 : w_mem_addr;
    assign mem_wdata_o = rst_i ? '0 : w_mem_wdata;

    // State register; reset drops any half-finished RMW without writing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the partial-write request so the merge does not depend on the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= w_idx;
            r_be    <= be_i;
            r_wdata <= wdata_i;
        end
    end

    // Response pipeline: every grant produces exactly one response the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_was_read <= 1'b0;
            r_opc      <= 1'b0;
        end else begin
            r_valid    <= w_gnt;
            r_was_read <= w_gnt & w_resp_read;
            r_opc      <= w_gnt & w_resp_opc;
        end
    end

    assign r_valid_o = r_valid;
    assign r_opc_o   = r_opc;
    assign r_rdata_o = (r_valid & r_was_read) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_l2_bank_adapter.sv
// Directed testbench for l2_bank_adapter with a behavioural single-port SRAM.
// The SRAM model registers read data one cycle after a read strobe and commits
// writes on the strobe edge. Inputs change 1ns after the rising edge, and checks
// happen 2ns after the rising edge.
module tb_l2_bank_adapter;

    logic        clock;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        wen;
    logic [4:0]  be;
    logic [39:0] wdata;
    logic        gnt;
    logic        rValid;
    logic [39:0] rRdata;
    logic        rOpc;
    logic        memReq;
    logic        memWe;
    logic [11:0] memAddr;
    logic [39:0] memWdata;
    logic [39:0] memRdata;

    logic [39:0] sramMem [0:4095];
    logic [39:0] seqData [0:3];

    int nCompared;
    int nMismatched;

    l2_bank_adapter dut (
        .clk_i       (clock),
        .rst_i       (reset),
        .req_i       (req),
        .add_i       (addr),
        .wen_i       (wen),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .r_valid_o   (rValid),
        .r_rdata_o   (rRdata),
        .r_opc_o     (rOpc),
        .mem_req_o   (memReq),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata)
    );

    // Free-running 10ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port SRAM model: write on strobe, read data appears the cycle after.
    always @(posedge clock) begin
        if (memReq) begin
            if (memWe) begin
                sramMem[memAddr] <= memWdata;
            end else begin
                memRdata <= sramMem[memAddr];
            end
        end
    end

    task automatic applyStimulus(input logic iReq, input logic iWen, input logic [4:0] iBe,
                                 input logic [31:0] iAddr, input logic [39:0] iWdata);
        req   = iReq;
        wen   = iWen;
        be    = iBe;
        addr  = iAddr;
        wdata = iWdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed sequence covering reset, full/partial/empty writes, reads, abort and aliasing.
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        memRdata    = '0;
        reset       = 1'b1;
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        #2;

        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_rvalid", rValid, 0);
        checkOutput("rst_ropc", rOpc, 0);
        checkOutput("rst_rdata", rRdata, 0);
        checkOutput("rst_memreq", memReq, 0);
        checkOutput("rst_memwe", memWe, 0);
        checkOutput("rst_memaddr", memAddr, 0);
        checkOutput("rst_memwdata", memWdata, 0);

        tick();
        tick();
        reset = 1'b0;

        $display("[TB] full write then read");
        applyStimulus(1'b1, 1'b0, 5'h1F, 32'h0000_0010, 40'hAA_1234_5678);
        checkOutput("fw_gnt", gnt, 1);
        checkOutput("fw_memreq", memReq, 1);
        checkOutput("fw_memwe", memWe, 1);
        checkOutput("fw_memaddr", memAddr, 12'h001);
        checkOutput("fw_memwdata", memWdata, 40'hAA_1234_5678);
        tick();
        applyStimulus(1'b1, 1'b1, 5'h00, 32'h0000_0010, 40'h0);
        checkOutput("fw_rvalid", rValid, 1);
        checkOutput("fw_rdata", rRdata, 0);
        checkOutput("rd_gnt", gnt, 1);
        checkOutput("rd_memwe", memWe, 0);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("rd_rvalid", rValid, 1);
        checkOutput("rd_rdata", rRdata, 40'hAA_1234_5678);
        checkOutput("rd_ropc", rOpc, 0);

        $display("[TB] partial write then immediate read");
        tick();
        applyStimulus(1'b1, 1'b0, 5'b00001, 32'h0000_0010, 40'h00_0000_00FF);
        checkOutput("pw1_gnt", gnt, 0);
        checkOutput("pw1_memreq", memReq, 1);
        checkOutput("pw1_memwe", memWe, 0);
        checkOutput("pw1_memaddr", memAddr, 12'h001);
        tick();
        checkOutput("pw2_rvalid", rValid, 0);
        checkOutput("pw2_gnt", gnt, 1);
        checkOutput("pw2_memwe", memWe, 1);
        checkOutput("pw2_memaddr", memAddr, 12'h001);
        checkOutput("pw2_memwdata", memWdata, 40'hAA_1234_56FF);
        tick();
        applyStimulus(1'b1, 1'b1, 5'h00, 32'h0000_0010, 40'h0);
        checkOutput("pw3_rvalid", rValid, 1);
        checkOutput("pw3_rdata", rRdata, 0);
        checkOutput("rar_gnt", gnt, 1);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("rar_rvalid", rValid, 1);
        checkOutput("rar_rdata", rRdata, 40'hAA_1234_56FF);

        $display("[TB] back-to-back writes and reads on words 2..5");
        seqData[0] = 40'h11_0000_0001;
        seqData[1] = 40'h22_0000_0002;
        seqData[2] = 40'h33_0000_0003;
        seqData[3] = 40'h44_0000_0004;
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 5'h1F, 32'((k + 2) << 4), seqData[k]);
            checkOutput("b2bw_gnt", gnt, 1);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 5'h00, 32'((k + 2) << 4), 40'h0);
            checkOutput("b2br_gnt", gnt, 1);
            checkOutput("b2br_memaddr", memAddr, 64'(k + 2));
            checkOutput("b2br_rvalid", rValid, 1);
            if (k > 0) begin
                checkOutput("b2br_rdata", rRdata, seqData[k-1]);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("b2br_last_rvalid", rValid, 1);
        checkOutput("b2br_last_rdata", rRdata, seqData[3]);
        tick();
        checkOutput("b2br_idle_rvalid", rValid, 0);

        $display("[TB] write with no byte enables");
        applyStimulus(1'b1, 1'b0, 5'h00, 32'h0000_0010, 40'hFF_FFFF_FFFF);
        checkOutput("be0_gnt", gnt, 1);
        checkOutput("be0_memreq", memReq, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 5'h00, 32'h0000_0010, 40'h0);
        checkOutput("be0_rvalid", rValid, 1);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("be0_rdata", rRdata, 40'hAA_1234_56FF);

        $display("[TB] partial write aborted by dropping req");
        tick();
        applyStimulus(1'b1, 1'b0, 5'b00010, 32'h0000_0010, 40'h00_0000_7700);
        tick();
        applyStimulus(1'b0, 1'b0, 5'b00010, 32'h0000_0010, 40'h00_0000_7700);
        checkOutput("abort_gnt", gnt, 0);
        checkOutput("abort_memreq", memReq, 0);
        tick();
        checkOutput("abort_rvalid", rValid, 0);

        $display("[TB] reset during merge cycle");
        applyStimulus(1'b1, 1'b0, 5'b10000, 32'h0000_0010, 40'h55_0000_0000);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("rstmid_gnt", gnt, 0);
        checkOutput("rstmid_memreq", memReq, 0);
        checkOutput("rstmid_memwe", memWe, 0);
        checkOutput("rstmid_memaddr", memAddr, 0);
        checkOutput("rstmid_memwdata", memWdata, 0);
        checkOutput("rstmid_rvalid", rValid, 0);
        tick();
        checkOutput("rstmid_hold_memwe", memWe, 0);
        checkOutput("rstmid_hold_rvalid", rValid, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        tick();
        checkOutput("rstmid_after_rvalid", rValid, 0);
        applyStimulus(1'b1, 1'b1, 5'h00, 32'h0000_0010, 40'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("rstmid_rdata", rRdata, 40'hAA_1234_56FF);

        $display("[TB] upper address bits");
        tick();
        applyStimulus(1'b1, 1'b1, 5'h00, 32'h8000_0010, 40'h0);
        checkOutput("hi_gnt", gnt, 1);
`ifdef L2_BANK_ADAPTER_ADDR_CHECK_EN
        checkOutput("hi_memreq", memReq, 0);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("hi_rvalid", rValid, 1);
        checkOutput("hi_ropc", rOpc, 1);
        checkOutput("hi_rdata", rRdata, 0);
`else
        checkOutput("hi_memreq", memReq, 1);
        checkOutput("hi_memaddr", memAddr, 12'h001);
        tick();
        applyStimulus(1'b0, 1'b1, 5'h00, 32'h0, 40'h0);
        checkOutput("hi_rvalid", rValid, 1);
        checkOutput("hi_ropc", rOpc, 0);
        checkOutput("hi_rdata", rRdata, 40'hAA_1234_56FF);
`endif
        tick();
        checkOutput("end_rvalid", rValid, 0);
        checkOutput("end_ropc", rOpc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
